ram_port_master: RTL and testbench
==================================

# ram_port_master

Initiator that drives one port of the dual-port RAM (clk/we/din/dout/addr port bundle) from a valid/ready request stream and returns read data on a valid/ready response stream. Absorbs the RAM's one-cycle registered read latency with a small response FIFO and credit counting, so read throughput is one per cycle under no backpressure. Also provides a hardware clear engine that sweeps every address to a fixed value. Sits between a bus/datapath client and either port of the RAM.

## Interface
- DEPTH, 256, number of RAM words
- AWID, 8, address width; DEPTH <= 2**AWID
- DWID, 16, data width
- CLR_VAL, 0, DWID-bit value written by the clear engine
- ctl__clk  in  1  single clock for all logic; also driven out on ram__clk
- ctl__rst_n  in  1  reset, asynchronous, active-low
- req__valid  in  1  request present
- req__ready  out  1  request accepted when valid & ready
- req__we  in  1  1 = write, 0 = read
- req__addr  in  AWID  request address
- req__din  in  DWID  write data (ignored for reads)
- rsp__valid  out  1  read data available
- rsp__ready  in  1  consumer takes data when valid & ready
- rsp__dout  out  DWID  read data
- clr__start  in  1  single-cycle pulse to start a clear sweep
- clr__busy  out  1  clear sweep in progress
- ram__clk  out  1  = ctl__clk
- ram__we, ram__addr (AWID), ram__din (DWID)  out  RAM port controls
- ram__dout  in  DWID  RAM registered read data

## Operation
- FSM states: IDLE, CLEAR. Reset -> IDLE.
- IDLE: req__ready = rst_n & (inflight + fifo_count < 3). Same rule for reads and writes.
- Accepted request drives RAM combinationally in the same cycle: ram__we = req__we, ram__addr = req__addr, ram__din = req__din. No handshake -> ram__we = 0, addr/din don't-care (hold 0).
- Accepted read sets inflight = 1 for next cycle; in that next cycle ram__dout is pushed into the 3-entry response FIFO. Writes generate no response.
- Response FIFO: rsp__valid = !empty, rsp__dout = head. Push and pop in same cycle allowed. Credit rule guarantees no overflow.
- Ordering: responses in request order. RAM is read-old-on-write per port: a read in the cycle after a write to the same address returns the new data.
- clr__start in IDLE -> CLEAR next cycle. A request handshaking in the same cycle as clr__start completes normally first. clr__start in CLEAR ignored.
- CLEAR: req__ready = 0; counter 0..DEPTH-1, one write per cycle, ram__we = 1, ram__addr = counter, ram__din = CLR_VAL. After address DEPTH-1 -> IDLE. clr__busy = 1 exactly in CLEAR. An in-flight read from the cycle before CLEAR still lands in the FIFO; FIFO may drain during CLEAR.
- Reset asserted mid-operation: FSM -> IDLE, counter 0, inflight 0, FIFO emptied; partially cleared memory left as is; pending responses discarded.

## Timing
- Reset values: req__ready 0 while rst_n low, rsp__valid 0, clr__busy 0, ram__we 0, ram__addr 0, ram__din 0.
- Read latency: request handshake cycle N -> rsp__valid earliest cycle N+2 (data registered by RAM at end of N, pushed at end of N+1).
- Throughput: back-to-back reads with rsp__ready held high accepted every cycle.
- Backpressure: rsp__ready low -> at most 3 read responses buffered; req__ready drops when inflight + count = 3.
- Clear: clr__start cycle N -> clr__busy cycles N+1..N+DEPTH, req__ready 1 again at N+DEPTH+1 (if credit available).

## Structure
- Package ram_pkg: state enum (IDLE, CLEAR), constant RSP_DEPTH = 3, credit-count width.
- One sub-module: ram_rsp_fifo (RSP_DEPTH-entry, DWID-wide, push/pop/count, async active-low reset).
- Top holds FSM, clear counter, inflight flag, RAM port muxing.

## Test plan
- Write 0x1234 @0x05, then read @0x05 -> rsp__dout 0x1234 two cycles after read handshake.
- 8 back-to-back reads @0..7 with rsp__ready=1 -> req__ready never drops, 8 responses in order on consecutive cycles.
- rsp__ready=0, issue reads -> exactly 3 accepted, req__ready 0; release -> 3 responses in order, then accepts resume.
- clr__start with DEPTH=16, CLR_VAL=0xA5A5 -> clr__busy 16 cycles, req__ready 0 throughout; subsequent reads of all addresses return 0xA5A5.
- clr__start same cycle as read handshake @0x03 (pre-written 0x0007) -> response 0x0007 delivered; clear still completes.
- Assert ctl__rst_n low mid-clear and with 2 buffered responses -> rsp__valid 0, clr__busy 0 immediately; after release, normal read works.

Source files
------------

// File: rtl/ram_pkg.sv
// ============================================================================
// Module      : ram_pkg
// Description : Shared types and constants for the RAM port master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int RSP_DEPTH = 3;
    localparam int CRD_W     = $clog2(RSP_DEPTH + 1);

endpackage

`default_nettype wire

// File: rtl/ram_rsp_fifo.sv
// ============================================================================
// Module      : ram_rsp_fifo
// Description : Small read-response FIFO with occupancy count, any depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_rsp_fifo
    import ram_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH,
    parameter int DWID  = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic [DWID-1:0] i_push_data,
    input  logic            i_pop,
    output logic [DWID-1:0] o_head,
    output logic            o_empty,
    output logic [CW-1:0]   o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWID-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

`default_nettype wire

// File: rtl/ram_port_master.sv
// ============================================================================
// Module      : ram_port_master
// Description : Drives one RAM port from a request stream, returns read data
//               on a response stream, and provides a full-memory clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_master
    import ram_pkg::*;
#(
    parameter int              DEPTH   = 256,
    parameter int              AWID    = 8,
    parameter int              DWID    = 16,
    parameter logic [DWID-1:0] CLR_VAL = '0
) (
    input  logic            ctl__clk,
    input  logic            ctl__rst_n,
    input  logic            req__valid,
    output logic            req__ready,
    input  logic            req__we,
    input  logic [AWID-1:0] req__addr,
    input  logic [DWID-1:0] req__din,
    output logic            rsp__valid,
    input  logic            rsp__ready,
    output logic [DWID-1:0] rsp__dout,
    input  logic            clr__start,
    output logic            clr__busy,
    output logic            ram__clk,
    output logic            ram__we,
    output logic [AWID-1:0] ram__addr,
    output logic [DWID-1:0] ram__din,
    input  logic [DWID-1:0] ram__dout
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AWID-1:0] r_clr_cnt;
    logic            r_inflight;
    logic [CRD_W-1:0] w_count;
    logic [CRD_W:0]  w_credit_used;
    logic            w_credit_ok;
    logic            w_fifo_empty;
    logic            w_req_fire;
    logic            w_clr_last;

    assign ram__clk = ctl__clk;

    // A read in flight already owns a FIFO slot, so it counts against credit.
    assign w_credit_used = (CRD_W + 1)'(r_inflight) + (CRD_W + 1)'(w_count);
    assign w_credit_ok   = (w_credit_used < (CRD_W + 1)'(RSP_DEPTH));
    assign w_req_fire    = req__valid & req__ready;
    assign w_clr_last    = (r_clr_cnt == AWID'(DEPTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        req__ready  = 1'b0;
        clr__busy   = 1'b0;
        ram__we     = 1'b0;
        ram__addr   = '0;
        ram__din    = '0;
        case (r_state)
            ST_IDLE: begin
                req__ready = ctl__rst_n & w_credit_ok;
                if (req__valid & req__ready) begin
                    ram__we   = req__we;
                    ram__addr = req__addr;
                    ram__din  = req__din;
                end
                if (clr__start) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr__busy = 1'b1;
                ram__we   = 1'b1;
                ram__addr = r_clr_cnt;
                ram__din  = CLR_VAL;
                if (w_clr_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ctl__clk or negedge ctl__rst_n) begin
        if (!ctl__rst_n) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_req_fire & ~req__we;
            if (r_state == ST_CLEAR && !w_clr_last) r_clr_cnt <= r_clr_cnt + 1'b1;
            else                                    r_clr_cnt <= '0;
        end
    end

    // RAM output register holds the data one cycle after the read was issued.
    ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .DWID  (DWID),
        .CW    (CRD_W)
    ) u_rsp_fifo (
        .clk         (ctl__clk),
        .rst_n       (ctl__rst_n),
        .i_push      (r_inflight),
        .i_push_data (ram__dout),
        .i_pop       (rsp__ready),
        .o_head      (rsp__dout),
        .o_empty     (w_fifo_empty),
        .o_count     (w_count)
    );

    assign rsp__valid = ~w_fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_master.sv
// ============================================================================
// Module      : tb_ram_port_master
// Description : Directed self-checking bench for ram_port_master with a
//               single-port registered-read RAM model on the RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_addr;
    logic [15:0] req_din;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_dout;
    logic        clr_start, clr_busy;
    logic        ram_clk, ram_we;
    logic [3:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [15:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_port_master #(
        .DEPTH   (16),
        .AWID    (4),
        .DWID    (16),
        .CLR_VAL (16'hA5A5)
    ) dut (
        .ctl__clk   (clk),
        .ctl__rst_n (rst_n),
        .req__valid (req_valid),
        .req__ready (req_ready),
        .req__we    (req_we),
        .req__addr  (req_addr),
        .req__din   (req_din),
        .rsp__valid (rsp_valid),
        .rsp__ready (rsp_ready),
        .rsp__dout  (rsp_dout),
        .clr__start (clr_start),
        .clr__busy  (clr_busy),
        .ram__clk   (ram_clk),
        .ram__we    (ram_we),
        .ram__addr  (ram_addr),
        .ram__din   (ram_din),
        .ram__dout  (ram_dout)
    );

    // Read-old-on-write RAM port with registered output
    always @(posedge ram_clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Returns in the cycle after the handshake.
    task automatic do_req(input logic we, input logic [3:0] a, input logic [15:0] d);
        int k;
        req_valid = 1'b1; req_we = we; req_addr = a; req_din = d;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (k == 50) check("req_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
        int k;
        do_req(1'b0, a, 16'h0);
        for (k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
            @(posedge clk); #1;
        end
        check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        check({tag, "_dat"}, 32'(rsp_dout), 32'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, got, nb;
        rst_n = 1'b0; rsp_ready = 1'b1; clr_start = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h5; req_din = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_clr_busy",  32'(clr_busy),  0);
        check("rst_ram_we",    32'(ram_we),    0);
        check("rst_ram_addr",  32'(ram_addr),  0);
        check("rst_ram_din",   32'(ram_din),   0);
        req_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;

        // Write then read the same address on the very next cycle
        do_req(1'b1, 4'h5, 16'h1234);
        do_req(1'b0, 4'h5, 16'h0);
        @(negedge clk);
        check("lat_n1_vld", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_n2_vld", 32'(rsp_valid), 1);
        check("lat_n2_dat", 32'(rsp_dout), 32'h1234);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) do_req(1'b1, 4'(i), 16'h0100 + 16'(i));

        // Back-to-back reads, no backpressure
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8); req_we = 1'b0; req_addr = 4'(k);
            @(negedge clk);
            if (k < 8) check("b2b_rdy", 32'(req_ready), 1);
            check("b2b_vld", 32'(rsp_valid), 32'(k >= 2 && k < 10));
            if (k >= 2 && k < 10) check("b2b_dat", 32'(rsp_dout), 32'h0100 + 32'(k - 2));
            @(posedge clk); #1;
        end
        req_valid = 1'b0;

        // Backpressure: only three reads may be outstanding
        rsp_ready = 1'b0; acc = 0;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(acc);
            @(negedge clk);
            if (req_ready) acc++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_accepted", 32'(acc), 3);
        check("bp_rdy_low",  32'(req_ready), 0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_drain_vld", 32'(rsp_valid), 1);
            check("bp_drain_dat", 32'(rsp_dout), 32'h0100 + 32'(k));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_empty",   32'(rsp_valid), 0);
        check("bp_resumed", 32'(req_ready), 1);
        @(posedge clk); #1;

        // Clear sweep
        clr_start = 1'b1;
        @(negedge clk);
        check("clr_busy_n", 32'(clr_busy), 0);
        @(posedge clk); #1; clr_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("clr_busy",  32'(clr_busy),  1);
            check("clr_rdy",   32'(req_ready), 0);
            check("clr_addr",  32'(ram_addr),  32'(k));
            check("clr_din",   32'(ram_din),   32'hA5A5);
            check("clr_we",    32'(ram_we),    1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("clr_done_busy", 32'(clr_busy),  0);
        check("clr_done_rdy",  32'(req_ready), 1);
        @(posedge clk); #1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            req_valid = (k < 16); req_we = 1'b0; req_addr = 4'(k);
            @(negedge clk);
            if (k < 16) check("clr_rd_rdy", 32'(req_ready), 1);
            if (rsp_valid) begin
                check("clr_rd_dat", 32'(rsp_dout), 32'hA5A5);
                got++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("clr_rd_cnt", 32'(got), 16);

        // Read handshake in the same cycle as clr__start
        do_req(1'b1, 4'h3, 16'h0007);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h3; clr_start = 1'b1;
        @(negedge clk);
        check("cs_rdy", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0; clr_start = 1'b0; nb = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == 0) check("cs_vld_n1", 32'(rsp_valid), 0);
            if (j == 1) begin
                check("cs_vld_n2", 32'(rsp_valid), 1);
                check("cs_dat",    32'(rsp_dout), 32'h0007);
            end
            if (!clr_busy) break;
            nb++;
            @(posedge clk); #1;
        end
        check("cs_busy_len", 32'(nb), 16);
        check("cs_rdy_after", 32'(req_ready), 1);
        @(posedge clk); #1;
        rd_check("cs_cleared", 4'h3, 16'hA5A5);

        // Reset in the middle of a clear with responses buffered
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h0;
        @(negedge clk); check("rr_rdy0", 32'(req_ready), 1);
        @(posedge clk); #1; req_addr = 4'h1;
        @(negedge clk); check("rr_rdy1", 32'(req_ready), 1);
        @(posedge clk); #1; req_valid = 1'b0; clr_start = 1'b1;
        @(posedge clk); #1; clr_start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rr_pre_busy", 32'(clr_busy),  1);
        check("rr_pre_vld",  32'(rsp_valid), 1);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("rr_vld",  32'(rsp_valid), 0);
        check("rr_busy", 32'(clr_busy),  0);
        check("rr_we",   32'(ram_we),    0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        check("rr_post_vld",  32'(rsp_valid), 0);
        check("rr_post_rdy",  32'(req_ready), 1);
        check("rr_post_busy", 32'(clr_busy),  0);
        @(posedge clk); #1;
        do_req(1'b1, 4'h9, 16'hBEEF);
        rd_check("rr_read", 4'h9, 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
